// File: rtl/sram_sched_pkg.sv
// Shared types and constants for the external SRAM scheduler.
//   state_t : access sequencer states
//   GNT_*   : grant identifiers (also used as port ids)
//   ADDR_W  : SRAM address width (512 KB -> 19 bits)
package sram_sched_pkg;

  localparam int ADDR_W = 19;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_VID  = 2'd1;
  localparam logic [1:0] GNT_CPU  = 2'd2;
  localparam logic [1:0] GNT_AUX  = 2'd3;

endpackage

// File: rtl/sram_sched_prio.sv
// Combinational winner select for the SRAM scheduler.
//   *_req  : request levels from video, cpu and aux
//   *_ack  : acknowledge currently high; that port may not win this cycle
//   starve : aux has lost too often and outranks cpu
//   winner : GNT_NONE / GNT_VID / GNT_CPU / GNT_AUX
module sram_sched_prio
  import sram_sched_pkg::*;
(
  input  logic       vid_req,
  input  logic       cpu_req,
  input  logic       aux_req,
  input  logic       vid_ack,
  input  logic       cpu_ack,
  input  logic       aux_ack,
  input  logic       starve,
  output logic [1:0] winner
);

  logic vid_ok;
  logic cpu_ok;
  logic aux_ok;

  assign vid_ok = vid_req & ~vid_ack;
  assign cpu_ok = cpu_req & ~cpu_ack;
  assign aux_ok = aux_req & ~aux_ack;

  // Video always first; starvation only swaps the cpu/aux order.
  always_comb begin
    winner = GNT_NONE;
    if (vid_ok) begin
      winner = GNT_VID;
    end else if (starve) begin
      if (aux_ok)      winner = GNT_AUX;
      else if (cpu_ok) winner = GNT_CPU;
    end else begin
      if (cpu_ok)      winner = GNT_CPU;
      else if (aux_ok) winner = GNT_AUX;
    end
  end

endmodule

// File: rtl/sram_sched.sv
// Three-way sequencer/arbiter for the external 512 KB SRAM.
// Each access: SETUP (1) -> STROBE (WAIT_STATES+1) -> HOLD (writes only, 1),
// then a one-cycle ack to the served port in the following IDLE cycle.
//   clk, rst_n            : memory clock, synchronous active-low reset
//   vid_*                 : video read port (req/addr in, ack/dout out)
//   cpu_*, aux_*          : read/write ports (req/we/addr/din in, ack/dout out)
//   sram_a/d_out/d_oe/we_n: registered SRAM pin drive
//   sram_d_in             : SRAM read data
//   grant                 : port in service (0 none, 1 vid, 2 cpu, 3 aux)
module sram_sched
  import sram_sched_pkg::*;
#(
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned STARVE_LIMIT = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [7:0]        vid_dout,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic              cpu_ack,
  output logic [7:0]        cpu_dout,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [7:0]        aux_din,
  output logic              aux_ack,
  output logic [7:0]        aux_dout,
  output logic [ADDR_W-1:0] sram_a,
  output logic [7:0]        sram_d_out,
  output logic              sram_d_oe,
  input  logic [7:0]        sram_d_in,
  output logic              sram_we_n,
  output logic [1:0]        grant
);

  localparam logic [7:0] WS_LAST    = 8'(WAIT_STATES);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t     state;
  logic [7:0] wcnt;
  logic [3:0] starve_cnt;
  logic       cur_we;
  logic [1:0] winner;

  sram_sched_prio u_prio (
    .vid_req (vid_req),
    .cpu_req (cpu_req),
    .aux_req (aux_req),
    .vid_ack (vid_ack),
    .cpu_ack (cpu_ack),
    .aux_ack (aux_ack),
    .starve  (starve_cnt == STARVE_MAX),
    .winner  (winner)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wcnt       <= '0;
      starve_cnt <= '0;
      cur_we     <= 1'b0;
      grant      <= GNT_NONE;
      sram_a     <= '0;
      sram_d_out <= '0;
      sram_d_oe  <= 1'b0;
      sram_we_n  <= 1'b1;
      vid_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      aux_ack    <= 1'b0;
      vid_dout   <= '0;
      cpu_dout   <= '0;
      aux_dout   <= '0;
    end else begin
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      aux_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (winner != GNT_NONE) begin
            state <= SETUP;
            grant <= winner;
            wcnt  <= '0;
            case (winner)
              GNT_VID: begin
                sram_a    <= vid_addr;
                cur_we    <= 1'b0;
                sram_d_oe <= 1'b0;
              end
              GNT_CPU: begin
                sram_a    <= cpu_addr;
                cur_we    <= cpu_we;
                sram_d_oe <= cpu_we;
                if (cpu_we) sram_d_out <= cpu_din;
              end
              default: begin
                sram_a    <= aux_addr;
                cur_we    <= aux_we;
                sram_d_oe <= aux_we;
                if (aux_we) sram_d_out <= aux_din;
              end
            endcase
            if (winner == GNT_AUX)
              starve_cnt <= '0;
            else if (aux_req && starve_cnt != STARVE_MAX)
              starve_cnt <= starve_cnt + 4'd1;
          end
        end
        SETUP: begin
          state     <= STROBE;
          sram_we_n <= ~cur_we;
        end
        STROBE: begin
          if (wcnt == WS_LAST) begin
            if (cur_we) begin
              state     <= HOLD;
              sram_we_n <= 1'b1;
            end else begin
              state <= IDLE;
              grant <= GNT_NONE;
              case (grant)
                GNT_VID: begin vid_dout <= sram_d_in; vid_ack <= 1'b1; end
                GNT_CPU: begin cpu_dout <= sram_d_in; cpu_ack <= 1'b1; end
                GNT_AUX: begin aux_dout <= sram_d_in; aux_ack <= 1'b1; end
                default: ;
              endcase
            end
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        HOLD: begin
          state     <= IDLE;
          grant     <= GNT_NONE;
          sram_d_oe <= 1'b0;
          case (grant)
            GNT_CPU: cpu_ack <= 1'b1;
            GNT_AUX: aux_ack <= 1'b1;
            default: ;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_sched.sv
module tb_sram_sched;

  localparam int NI = 3;

  function automatic int unsigned ws_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
  endfunction

  function automatic logic [7:0] pat(input logic [18:0] a);
    if (a == 19'h12345) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h5C;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        vid_req, cpu_req, cpu_we, aux_req, aux_we;
  logic [18:0] vid_addr, cpu_addr, aux_addr;
  logic [7:0]  cpu_din, aux_din;

  logic        vid_ack[NI], cpu_ack[NI], aux_ack[NI];
  logic [7:0]  vid_dout[NI], cpu_dout[NI], aux_dout[NI];
  logic [18:0] sram_a[NI];
  logic [7:0]  sram_d_out[NI], sram_d_in[NI];
  logic        sram_d_oe[NI], sram_we_n[NI];
  logic [1:0]  grant[NI];

  for (genvar g = 0; g < NI; g++) begin : gi
    logic [7:0] mem [524288];
    initial for (int a = 0; a < 524288; a++) mem[a] = pat(19'(a));
    always @(negedge clk) if (!sram_we_n[g]) mem[sram_a[g]] = sram_d_out[g];
    assign sram_d_in[g] = mem[sram_a[g]];

    sram_sched #(.WAIT_STATES(ws_of(g)), .STARVE_LIMIT(7)) dut (
      .clk(clk), .rst_n(rst_n),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack[g]), .vid_dout(vid_dout[g]),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_ack(cpu_ack[g]), .cpu_dout(cpu_dout[g]),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_din(aux_din),
      .aux_ack(aux_ack[g]), .aux_dout(aux_dout[g]),
      .sram_a(sram_a[g]), .sram_d_out(sram_d_out[g]), .sram_d_oe(sram_d_oe[g]),
      .sram_d_in(sram_d_in[g]), .sram_we_n(sram_we_n[g]), .grant(grant[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ack_of(input int g, input logic [1:0] p);
    case (p)
      2'd1:    return vid_ack[g];
      2'd2:    return cpu_ack[g];
      default: return aux_ack[g];
    endcase
  endfunction

  function automatic logic [7:0] dout_of(input int g, input logic [1:0] p);
    case (p)
      2'd1:    return vid_dout[g];
      2'd2:    return cpu_dout[g];
      default: return aux_dout[g];
    endcase
  endfunction

  task automatic set_port(input logic [1:0] p, input logic rq, input logic we,
                          input logic [18:0] a, input logic [7:0] d);
    case (p)
      2'd1:    begin vid_req = rq; vid_addr = a; end
      2'd2:    begin cpu_req = rq; cpu_we = we; cpu_addr = a; cpu_din = d; end
      default: begin aux_req = rq; aux_we = we; aux_addr = a; aux_din = d; end
    endcase
  endtask

  task automatic reset_chk(input int g, input string tag);
    chk({tag, "_sram_a"}, sram_a[g], 0);
    chk({tag, "_d_out"}, sram_d_out[g], 0);
    chk({tag, "_d_oe"}, sram_d_oe[g], 0);
    chk({tag, "_we_n"}, sram_we_n[g], 1);
    chk({tag, "_grant"}, grant[g], 0);
    chk({tag, "_acks"}, {vid_ack[g], cpu_ack[g], aux_ack[g]}, 0);
    chk({tag, "_douts"}, {vid_dout[g], cpu_dout[g], aux_dout[g]}, 0);
  endtask

  typedef struct {
    logic [1:0]  port;
    logic        we;
    logic [18:0] addr;
    logic [7:0]  din;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t tbl[8];
  logic [1:0] exp_starve[17] = '{1, 2, 1, 2, 1, 2, 1, 3, 1, 2, 1, 2, 1, 2, 1, 3, 1};
  logic [1:0] exp_alt[6]     = '{1, 2, 1, 2, 1, 2};

  int         gk[NI], ak[NI], wl[NI];
  bit         ok[NI];
  logic [7:0] dv[NI];
  logic [1:0] seq[$];
  logic [1:0] prevg;
  bit         found, all_done;
  int         acks_seen;

  // reference model state for the randomized phase
  bit         busy, mwe;
  logic [1:0] mp, w;
  int         mg, mdone, mst;
  logic [18:0] maddr;
  logic [7:0] mdin;
  bit         mack[4], ackp[4], el[4];
  logic [7:0] edout[4];
  logic [7:0] shadow[256];
  bit         rq[4], rwe[4];
  logic [18:0] raddr[4];
  logic [7:0] rdin[4];

  task automatic new_req(input int p);
    rwe[p]   = (p != 1) && ($urandom_range(0, 1) == 1);
    raddr[p] = 19'h40000 | 19'($urandom_range(0, 255));
    rdin[p]  = 8'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_port(2'd1, 0, 0, '0, '0);
    set_port(2'd2, 0, 0, '0, '0);
    set_port(2'd3, 0, 0, '0, '0);
    tbl[0] = '{2'd2, 1'b0, 19'h12345, 8'h00, 8'hA5};
    tbl[1] = '{2'd2, 1'b1, 19'h00010, 8'h3C, 8'h00};
    tbl[2] = '{2'd2, 1'b0, 19'h00010, 8'h00, 8'h3C};
    tbl[3] = '{2'd3, 1'b1, 19'h7FFFF, 8'h5A, 8'h00};
    tbl[4] = '{2'd3, 1'b0, 19'h7FFFF, 8'h00, 8'h5A};
    tbl[5] = '{2'd1, 1'b0, 19'h00000, 8'h00, 8'h5C};
    tbl[6] = '{2'd1, 1'b0, 19'h12345, 8'h00, 8'hA5};
    tbl[7] = '{2'd3, 1'b0, 19'h00010, 8'h00, 8'h3C};

    repeat (3) tick();
    for (int g = 0; g < NI; g++) reset_chk(g, "reset");
    rst_n = 1'b1;
    tick();

    // single transactions on all three wait-state variants at once
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < NI; g++) begin
        gk[g] = 0; ak[g] = 0; wl[g] = 0; ok[g] = 1; dv[g] = '0;
      end
      set_port(tbl[i].port, 1'b1, tbl[i].we, tbl[i].addr, tbl[i].din);
      for (int k = 1; k <= 15; k++) begin
        tick();
        all_done = 1;
        for (int g = 0; g < NI; g++) begin
          if (gk[g] == 0 && grant[g] == tbl[i].port) gk[g] = k;
          if (gk[g] != 0 && ak[g] == 0) begin
            if (ack_of(g, tbl[i].port)) begin
              ak[g] = k;
              dv[g] = dout_of(g, tbl[i].port);
            end else begin
              if (!sram_we_n[g]) wl[g]++;
              if (tbl[i].we)
                ok[g] = ok[g] && sram_a[g] == tbl[i].addr && sram_d_out[g] == tbl[i].din && sram_d_oe[g];
              else
                ok[g] = ok[g] && sram_a[g] == tbl[i].addr && !sram_d_oe[g] && sram_we_n[g];
            end
          end
          if (ak[g] == 0) all_done = 0;
        end
        if (all_done) break;
      end
      set_port(tbl[i].port, 1'b0, 1'b0, '0, '0);
      repeat (10) tick();
      for (int g = 0; g < NI; g++) begin
        chk($sformatf("vec%0d_ws%0d_grant_edge", i, ws_of(g)), gk[g], 1);
        chk($sformatf("vec%0d_ws%0d_latency", i, ws_of(g)), ak[g] - gk[g],
            (tbl[i].we ? 3 : 2) + ws_of(g));
        chk($sformatf("vec%0d_ws%0d_pins", i, ws_of(g)), ok[g], 1);
        chk($sformatf("vec%0d_ws%0d_we_low", i, ws_of(g)), wl[g],
            tbl[i].we ? ws_of(g) + 1 : 0);
        if (!tbl[i].we)
          chk($sformatf("vec%0d_ws%0d_dout", i, ws_of(g)), dv[g], tbl[i].exp_dout);
      end
    end

    // all three held: aux must get in after seven lost arbitrations
    set_port(2'd1, 1, 0, 19'h00100, 8'h00);
    set_port(2'd2, 1, 0, 19'h00200, 8'h00);
    set_port(2'd3, 1, 0, 19'h00300, 8'h00);
    seq.delete();
    prevg = 2'd0;
    for (int k = 0; k < 200 && seq.size() < 17; k++) begin
      tick();
      if (grant[0] != 0 && prevg == 0) seq.push_back(grant[0]);
      prevg = grant[0];
    end
    set_port(2'd1, 0, 0, '0, '0);
    set_port(2'd2, 0, 0, '0, '0);
    set_port(2'd3, 0, 0, '0, '0);
    repeat (12) tick();
    chk("starve_grant_count", seq.size(), 17);
    for (int i = 0; i < seq.size() && i < 17; i++)
      chk($sformatf("starve_order%0d", i), seq[i], exp_starve[i]);

    // vid and cpu held: strict alternation, nobody regranted in its ack cycle
    set_port(2'd1, 1, 0, 19'h00400, 8'h00);
    set_port(2'd2, 1, 0, 19'h00500, 8'h00);
    seq.delete();
    prevg = 2'd0;
    for (int k = 0; k < 100 && seq.size() < 6; k++) begin
      tick();
      if (grant[0] != 0 && prevg == 0) seq.push_back(grant[0]);
      prevg = grant[0];
    end
    set_port(2'd1, 0, 0, '0, '0);
    set_port(2'd2, 0, 0, '0, '0);
    repeat (12) tick();
    chk("alt_grant_count", seq.size(), 6);
    for (int i = 0; i < seq.size() && i < 6; i++)
      chk($sformatf("alt_order%0d", i), seq[i], exp_alt[i]);

    // reset during the strobe of an aux write
    set_port(2'd3, 1, 1, 19'h7FFF0, 8'h77);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (grant[0] == 2'd3 && !sram_we_n[0]) begin
        found = 1;
        break;
      end
    end
    chk("rst_strobe_reached", found, 1);
    rst_n = 1'b0;
    set_port(2'd3, 0, 0, '0, '0);
    tick();
    reset_chk(0, "midrst");
    rst_n = 1'b1;
    acks_seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (aux_ack[0]) acks_seen++;
    end
    chk("midrst_no_aux_ack", acks_seen, 0);

    // randomized traffic against a transaction-level model of instance 0
    for (int i = 0; i < 256; i++) shadow[i] = pat(19'h40000 | 19'(i));
    busy = 0; mst = 0; mwe = 0; mp = 0; mg = 0; mdone = 0; maddr = '0; mdin = '0;
    for (int p = 0; p < 4; p++) begin
      mack[p] = 0; rq[p] = 0; rwe[p] = 0; raddr[p] = '0; rdin[p] = '0; edout[p] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int p = 0; p < 4; p++) begin ackp[p] = mack[p]; mack[p] = 0; end
      if (!busy) begin
        for (int p = 1; p < 4; p++) el[p] = rq[p] && !ackp[p];
        if (el[1])         w = 2'd1;
        else if (mst == 7) w = el[3] ? 2'd3 : (el[2] ? 2'd2 : 2'd0);
        else               w = el[2] ? 2'd2 : (el[3] ? 2'd3 : 2'd0);
        if (w == 2'd3) mst = 0;
        else if (rq[3] && w != 0 && mst < 7) mst++;
        if (w != 0) begin
          busy  = 1;
          mp    = w;
          mwe   = (w != 2'd1) && rwe[w];
          maddr = raddr[w];
          mdin  = rdin[w];
          mg    = c;
          mdone = c + (mwe ? 4 : 3);
        end
      end else if (c == mdone) begin
        busy = 0;
        mack[mp] = 1;
        if (mwe) shadow[maddr[7:0]] = mdin;
        else     edout[mp] = shadow[maddr[7:0]];
      end

      chk("rnd_grant", grant[0], busy ? mp : 2'd0);
      chk("rnd_vid_ack", vid_ack[0], mack[1]);
      chk("rnd_cpu_ack", cpu_ack[0], mack[2]);
      chk("rnd_aux_ack", aux_ack[0], mack[3]);
      for (int p = 1; p < 4; p++)
        if (mack[p] && !mwe) chk("rnd_dout", dout_of(0, 2'(p)), edout[p]);
      chk("rnd_d_oe", sram_d_oe[0], busy && mwe);
      chk("rnd_we_n", sram_we_n[0], !(busy && mwe && c >= mg + 1 && c <= mdone - 2));
      if (busy) chk("rnd_sram_a", sram_a[0], maddr);
      if (busy && mwe) chk("rnd_sram_d_out", sram_d_out[0], mdin);

      for (int p = 1; p < 4; p++) begin
        int r;
        r = $urandom_range(0, 15);
        if (mack[p]) begin
          rq[p] = (r < 8);
          new_req(p);
        end else if (rq[p] && busy && mp == 2'(p)) begin
          new_req(p);
        end else if (rq[p]) begin
          if (r == 0) rq[p] = 0;
        end else if (r < 4) begin
          rq[p] = 1;
          new_req(p);
        end
        set_port(2'(p), rq[p], rwe[p], raddr[p], rdin[p]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_sched.md
# sram_sched

Sequencer and arbiter for the single external 512 KB SRAM. Three requesters share it: ASIC video fetch, CPU, and an auxiliary port (disk-image/loader DMA). Each access runs as a fixed setup/strobe/hold sequence on the SRAM pins. Requesters see one-cycle acknowledge pulses. The block runs on the 50 MHz memory clock and replaces the two-way turn-based SRAM sharing with a scheduled three-way scheme.

## Interface
Parameters:
- WAIT_STATES, 1: extra strobe cycles per access (strobe lasts WAIT_STATES+1 cycles).
- STARVE_LIMIT, 7: consecutive lost arbitrations after which aux outranks cpu (1..15).

Ports:
- clk  in  1  memory clock, 50 MHz; single clock domain.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- vid_req  in  1  video read request, level, held until vid_ack.
- vid_addr  in  19  video address.
- vid_ack  out  1  one-cycle pulse; vid_dout valid in that cycle.
- vid_dout  out  8  last video read data, held.
- cpu_req, cpu_we  in  1 each  cpu request (level) / 1 = write.
- cpu_addr  in  19; cpu_din  in  8.
- cpu_ack  out  1; cpu_dout  out  8  as for video.
- aux_req, aux_we  in  1 each; aux_addr  in  19; aux_din  in  8.
- aux_ack  out  1; aux_dout  out  8.
- sram_a  out  19  SRAM address.
- sram_d_out  out  8; sram_d_oe  out  1  write data and its tristate enable. The top level builds the inout.
- sram_d_in  in  8  SRAM read data.
- sram_we_n  out  1  SRAM write strobe, active low.
- grant  out  2  port being served: 0 none, 1 vid, 2 cpu, 3 aux.

## Operation
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE: arbitrate among requests whose ack is not high this cycle.
  - Order: vid > cpu > aux.
  - If starve_cnt == STARVE_LIMIT: vid > aux > cpu.
  - On a winner: latch port, address, we, data; go to SETUP; grant = winner.
  - No winner: stay in IDLE; grant = 0.
- SETUP (1 cycle): sram_a driven; if write, sram_d_oe=1 and sram_d_out valid; sram_we_n=1.
- STROBE (WAIT_STATES+1 cycles):
  - Write: sram_we_n=0.
  - Read: sram_d_oe=0; on the final STROBE edge, capture sram_d_in into the winner's dout.
  - Exit: read goes to IDLE; write goes to HOLD.
- HOLD (writes only, 1 cycle): sram_we_n=1; address and data still driven. Then go to IDLE.
- The winner's ack pulses in the first IDLE cycle after completion. The same port cannot be regranted in that cycle.
- starve_cnt (4 bit):
  - Increments, saturating at STARVE_LIMIT, at each IDLE arbitration where aux_req=1 and aux loses.
  - Clears to 0 when aux is granted.
- Video is never write-capable; vid_we does not exist.
- Address and data are captured at grant. Requester inputs may change after grant without effect.

## Timing
- Read latency (request seen in IDLE at cycle 0 to ack): 2+WAIT_STATES cycles. Default: 3.
- Write latency: 3+WAIT_STATES cycles. Default: 4.
- Back-to-back: the next grant is in the ack cycle. Default throughput: one read per 3 cycles, one write per 4 cycles.
- sram_a, sram_we_n, sram_d_oe and sram_d_out are registered outputs; no combinational path from req to pins.
- sram_we_n never falls in the same cycle sram_a changes.
- sram_d_oe is 0 in every cycle where it is not a write in SETUP, STROBE or HOLD.
- Reset values: state IDLE, sram_a=0, sram_d_out=0, sram_d_oe=0, sram_we_n=1, all acks 0, all douts 0x00, grant=0, starve_cnt=0.
- Reset mid-access: abort at that edge; sram_we_n=1 and sram_d_oe=0 next cycle; no ack issued. The write in progress may be lost.
- Simultaneous requests from all three ports in IDLE: vid wins (unless starve, where only the aux/cpu order flips).
- A req dropped before grant is simply not served. A req dropped after grant still completes and acks.

## Structure
- Package sram_sched_pkg:
  - state enum (IDLE, SETUP, STROBE, HOLD);
  - grant id constants (GNT_NONE, GNT_VID, GNT_CPU, GNT_AUX);
  - 19-bit address width constant.
- Sub-module sram_sched_prio: combinational winner select from reqs, ack mask and starve flag. Kept separate so it can be checked exhaustively.
- Wait-state counter and starve counter stay in the top FSM.

## Test plan
- cpu read of 0x12345 with SRAM model returning 0xA5, WAIT_STATES=1 -> cpu_ack exactly 3 cycles after req; cpu_dout=0xA5; sram_we_n stays 1.
- cpu write 0x3C to 0x00010 -> sram_we_n low for 2 cycles, preceded and followed by one cycle with address and data stable and sram_d_oe=1; cpu_ack at cycle 4; model holds 0x3C.
- vid, cpu and aux req in the same cycle, all held -> served in order vid, cpu, vid... ; aux granted after its 7th lost arbitration, then starve_cnt=0.
- cpu and vid held continuously -> no port is granted twice in its own ack cycle; grant alternates vid/cpu.
- rst_n low during the STROBE of an aux write -> next cycle sram_we_n=1, sram_d_oe=0, grant=0; no aux_ack; all outputs at reset values.
- Sweep WAIT_STATES=0 and 3 -> read latency 2 and 5, write latency 3 and 6.
